// File: rtl/demux_1x4_tdm.sv
// Receive side of a 4-slot TDM link: rebuilds frames from a serial word stream and presents them on lanes a..d.
// Latency: a..d and frame_valid update on the edge that samples the slot-3 beat (one cycle after it is presented).
// Backpressure: none; in_valid gaps of any length hold slot position and shadow contents.
// Optional: define DEMUX_ERR_CNT_EN to add the saturating 8-bit err_cnt output.
module demux_1x4_tdm #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in,
    input  logic         in_valid,
    input  logic         frame_sync,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic         s1,
    output logic         s0,
    output logic         frame_valid,
    output logic         locked,
`ifdef DEMUX_ERR_CNT_EN
    output logic [7:0]   err_cnt,
`endif
    output logic         sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t       state, state_nxt;
    logic [1:0]   slot, slot_nxt;
    logic [W-1:0] shadow0, shadow1, shadow2;
    logic         ld0, ld1, ld2, commit, err;

    assign s1     = slot[1];
    assign s0     = slot[0];
    assign locked = (state == LOCK);

    // State register; a reset drops any partial frame and returns to hunting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a sync beat acquires lock, a missing sync at slot 0 loses it.
    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            case (state)
                HUNT: if (frame_sync) state_nxt = LOCK;
                LOCK: if (!frame_sync && slot == 2'd0) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Beat decode: which shadow to load, when to commit, when to flag a framing error.
    always_comb begin
        ld0      = 1'b0;
        ld1      = 1'b0;
        ld2      = 1'b0;
        commit   = 1'b0;
        err      = 1'b0;
        slot_nxt = slot;
        if (in_valid) begin
            if (state == HUNT) begin
                if (frame_sync) begin
                    ld0      = 1'b1;
                    slot_nxt = 2'd1;
                end
            end else if (frame_sync) begin
                // Sync always realigns to slot 0; arriving mid-frame it also discards the partial frame.
                ld0      = 1'b1;
                err      = (slot != 2'd0);
                slot_nxt = 2'd1;
            end else begin
                case (slot)
                    2'd0: begin
                        err      = 1'b1;
                        slot_nxt = 2'd0;
                    end
                    2'd1: begin
                        ld1      = 1'b1;
                        slot_nxt = 2'd2;
                    end
                    2'd2: begin
                        ld2      = 1'b1;
                        slot_nxt = 2'd3;
                    end
                    default: begin
                        commit   = 1'b1;
                        slot_nxt = 2'd0;
                    end
                endcase
            end
        end
    end

    // Slot counter, shadow registers and the atomic lane commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot        <= 2'd0;
            shadow0     <= '0;
            shadow1     <= '0;
            shadow2     <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            slot        <= slot_nxt;
            frame_valid <= commit;
            sync_err    <= err;
            if (ld0) shadow0 <= in;
            if (ld1) shadow1 <= in;
            if (ld2) shadow2 <= in;
            if (commit) begin
                a <= shadow0;
                b <= shadow1;
                c <= shadow2;
                d <= in;
            end
        end
    end

`ifdef DEMUX_ERR_CNT_EN
    // Error counter saturates at 255 so a long bad stretch never wraps back to a small value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x4_tdm.sv
// Directed bench for demux_1x4_tdm: basic, gapped, resync, missing-sync, pre-lock and async-reset frames.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the sampling rising edge.
// Build with DEMUX_ERR_CNT_EN defined to also exercise err_cnt saturation.
module tb_demux_1x4_tdm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in;
    logic       in_valid;
    logic       frame_sync;
    logic [7:0] a, b, c, d;
    logic       s1, s0, frame_valid, locked, sync_err;
`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_1x4_tdm #(.W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .in_valid    (in_valid),
        .frame_sync  (frame_sync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .s1          (s1),
        .s0          (s0),
        .frame_valid (frame_valid),
        .locked      (locked),
`ifdef DEMUX_ERR_CNT_EN
        .err_cnt     (err_cnt),
`endif
        .sync_err    (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one cycle of input (called on a falling edge) and return on the next falling edge.
    task automatic drive(input logic v, input logic [7:0] dat, input logic sync);
        in_valid   = v;
        in         = dat;
        frame_sync = sync;
        @(negedge clk);
        in_valid   = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic beat(input logic [7:0] dat, input logic sync);
        drive(1'b1, dat, sync);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_lanes(input string tag, input logic [31:0] exp);
        check({tag, ".abcd"}, {a, b, c, d}, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in         = 8'h00;
        in_valid   = 1'b0;
        frame_sync = 1'b0;

        // Reset state
        do_reset();
        check_lanes("rst", 32'h0000_0000);
        check("rst.locked", locked, 0);
        check("rst.fv", frame_valid, 0);
        check("rst.serr", sync_err, 0);
        check("rst.slot", {s1, s0}, 0);

        // Basic frame
        beat(8'h11, 1'b1);
        check("basic.locked", locked, 1);
        check("basic.slot1", {s1, s0}, 1);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        check("basic.slot3", {s1, s0}, 3);
        check("basic.fv_early", frame_valid, 0);
        beat(8'h44, 1'b0);
        check("basic.fv", frame_valid, 1);
        check_lanes("basic", 32'h1122_3344);
        check("basic.slot0", {s1, s0}, 0);
        idle();
        check("basic.fv_drop", frame_valid, 0);
        check_lanes("basic.hold", 32'h1122_3344);

        // Gapped beats
        beat(8'h55, 1'b1);
        idle();
        idle();
        check("gap.slot_hold", {s1, s0}, 1);
        check("gap.fv0", frame_valid, 0);
        beat(8'h66, 1'b0);
        idle();
        idle();
        check("gap.slot_hold2", {s1, s0}, 2);
        beat(8'h77, 1'b0);
        idle();
        idle();
        check("gap.fv1", frame_valid, 0);
        check_lanes("gap.old", 32'h1122_3344);
        beat(8'h88, 1'b0);
        check("gap.fv", frame_valid, 1);
        check_lanes("gap", 32'h5566_7788);
        idle();
        check("gap.fv_drop", frame_valid, 0);

        // Early resync
        beat(8'hA0, 1'b1);
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b0);
        check_lanes("resync.base", 32'hA0A1_A2A3);
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b1);
        check("resync.serr", sync_err, 1);
        check("resync.fv", frame_valid, 0);
        check("resync.locked", locked, 1);
        check("resync.slot", {s1, s0}, 1);
        check_lanes("resync.keep", 32'hA0A1_A2A3);
        beat(8'h04, 1'b0);
        check("resync.serr_drop", sync_err, 0);
        beat(8'h05, 1'b0);
        beat(8'h06, 1'b0);
        check("resync.fv_commit", frame_valid, 1);
        check("resync.serr_none", sync_err, 0);
        check_lanes("resync", 32'h0304_0506);

        // Missing sync
        beat(8'h77, 1'b0);
        check("miss.serr", sync_err, 1);
        check("miss.locked", locked, 0);
        check("miss.slot", {s1, s0}, 0);
        beat(8'h88, 1'b0);
        check("miss.serr_drop", sync_err, 0);
        beat(8'h99, 1'b0);
        check("miss.fv", frame_valid, 0);
        check("miss.locked2", locked, 0);
        check_lanes("miss.keep", 32'h0304_0506);
        beat(8'hB0, 1'b1);
        check("miss.relock", locked, 1);
        beat(8'hB1, 1'b0);
        beat(8'hB2, 1'b0);
        beat(8'hB3, 1'b0);
        check("miss.fv_relock", frame_valid, 1);
        check_lanes("miss.relock", 32'hB0B1_B2B3);

        // Pre-lock data after reset
        do_reset();
        for (int i = 0; i < 5; i++) begin
            beat(8'hC0 + 8'(i), 1'b0);
            check("prelock.fv", frame_valid, 0);
            check("prelock.locked", locked, 0);
        end
        check("prelock.slot", {s1, s0}, 0);
        check_lanes("prelock", 32'h0000_0000);

        // Async reset mid-frame
        beat(8'hD0, 1'b1);
        beat(8'hD1, 1'b0);
        beat(8'hD2, 1'b0);
        beat(8'hD3, 1'b0);
        check_lanes("arst.base", 32'hD0D1_D2D3);
        beat(8'hE0, 1'b1);
        beat(8'hE1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_lanes("arst.now", 32'h0000_0000);
        check("arst.locked", locked, 0);
        check("arst.slot", {s1, s0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(8'hF0, 1'b1);
        beat(8'hF1, 1'b0);
        beat(8'hF2, 1'b0);
        beat(8'hF3, 1'b0);
        check("arst.fv", frame_valid, 1);
        check_lanes("arst.clean", 32'hF0F1_F2F3);

`ifdef DEMUX_ERR_CNT_EN
        // Error counter saturation: first sync locks, each following sync at slot 1 is an error.
        do_reset();
        check("cnt.rst", err_cnt, 0);
        beat(8'h10, 1'b1);
        beat(8'h11, 1'b1);
        beat(8'h12, 1'b1);
        check("cnt.two", err_cnt, 2);
        for (int i = 0; i < 298; i++) begin
            beat(8'h20, 1'b1);
        end
        check("cnt.sat", err_cnt, 255);
        idle();
        check("cnt.hold", err_cnt, 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
